// File: rtl/branch_resolution_unit.sv
// Branch resolution: queues fetch-time BTB predictions, checks them against EX
// outcomes, drives the BTB update port and issues flushes on mispredicts.
module branch_resolution_unit #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_valid,
    input  logic [31:0] push_pc,
    input  logic        push_hit,
    input  logic [31:0] push_pred_pc,
    input  logic        push_pred_taken,
    input  logic        ex_valid,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        full,
    output logic        empty,
    output logic [2:0]  write_entry,
    output logic [31:0] pc_ip,
    output logic [31:0] pc_predicted_ip,
    output logic        taken_ip,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [15:0] mispredict_count,
    output logic        overflow,
    output logic        underflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic        hit;
        logic [31:0] pred_pc;
        logic        pred_taken;
    } pred_rec_t;

    pred_rec_t   mem [DEPTH];
    pred_rec_t   head;
    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic        do_pop, do_push, eff_taken, mispred;
    logic        full_n, empty_n, overflow_set, underflow_set;
    logic [2:0]  we_n;
    logic [31:0] pc_n, ppc_n, redirect_n;
    logic        tk_n;

    // Resolve/push decisions, next pointers and the next BTB command
    always_comb begin
        head          = mem[rd_ptr[AW-1:0]];
        do_pop        = ex_valid && !empty;
        eff_taken     = head.hit & head.pred_taken;
        mispred       = do_pop && ((eff_taken != ex_taken) ||
                                   (ex_taken && (head.pred_pc != ex_target)));
        do_push       = push_valid && !mispred && (!full || do_pop);
        overflow_set  = push_valid && full && !do_pop;
        underflow_set = ex_valid && empty;

        rd_ptr_n = rd_ptr;
        wr_ptr_n = wr_ptr;
        if (do_pop)  rd_ptr_n = rd_ptr + PW'(1);
        if (do_push) wr_ptr_n = wr_ptr + PW'(1);
        // Everything younger than a mispredicted branch is wrong-path
        if (mispred) rd_ptr_n = wr_ptr;
        if (mispred) wr_ptr_n = wr_ptr;

        empty_n = (wr_ptr_n == rd_ptr_n);
        full_n  = (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                  (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);

        // Update fields hold between commands: the BTB update path is level-sensitive
        we_n  = 3'b000;
        pc_n  = pc_ip;
        ppc_n = pc_predicted_ip;
        tk_n  = taken_ip;
        if (mispred && head.hit) begin
            we_n  = 3'b001;
            pc_n  = head.pc;
            ppc_n = ex_taken ? ex_target : head.pred_pc;
            tk_n  = ex_taken;
        end else if (do_pop && !head.hit && ex_taken) begin
            we_n  = 3'b010;
            pc_n  = head.pc;
            ppc_n = ex_target;
            tk_n  = 1'b1;
        end

        redirect_n = ex_taken ? ex_target : (head.pc + 32'd4);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= '{pc: push_pc, hit: push_hit,
                                     pred_pc: push_pred_pc, pred_taken: push_pred_taken};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            full             <= 1'b0;
            empty            <= 1'b1;
            write_entry      <= 3'b000;
            pc_ip            <= '0;
            pc_predicted_ip  <= '0;
            taken_ip         <= 1'b0;
            flush            <= 1'b0;
            redirect_pc      <= '0;
            mispredict_count <= '0;
            overflow         <= 1'b0;
            underflow        <= 1'b0;
        end else begin
            wr_ptr          <= wr_ptr_n;
            rd_ptr          <= rd_ptr_n;
            full            <= full_n;
            empty           <= empty_n;
            write_entry     <= we_n;
            pc_ip           <= pc_n;
            pc_predicted_ip <= ppc_n;
            taken_ip        <= tk_n;
            flush           <= mispred;
            if (mispred) redirect_pc <= redirect_n;
            if (mispred && (mispredict_count != 16'hFFFF)) begin
                mispredict_count <= mispredict_count + 16'd1;
            end
            if (overflow_set)  overflow  <= 1'b1;
            if (underflow_set) underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Scoreboard bench for branch_resolution_unit: directed resolves push expected
// BTB commands; a monitor compares them one cycle after each sampled resolve.
module tb_branch_resolution_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid, push_hit, push_pred_taken;
    logic [31:0] push_pc, push_pred_pc;
    logic        ex_valid, ex_taken;
    logic [31:0] ex_target;
    logic        full, empty, taken_ip, flush, overflow, underflow;
    logic [2:0]  write_entry;
    logic [31:0] pc_ip, pc_predicted_ip, redirect_pc;
    logic [15:0] mispredict_count;

    branch_resolution_unit #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_pc(push_pc), .push_hit(push_hit),
        .push_pred_pc(push_pred_pc), .push_pred_taken(push_pred_taken),
        .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_target(ex_target),
        .full(full), .empty(empty), .write_entry(write_entry), .pc_ip(pc_ip),
        .pc_predicted_ip(pc_predicted_ip), .taken_ip(taken_ip), .flush(flush),
        .redirect_pc(redirect_pc), .mispredict_count(mispredict_count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  we;
        logic [31:0] pc;
        logic [31:0] ppc;
        logic        tk;
        logic        fl;
        logic [31:0] rpc;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_pc, last_ppc;
    logic        last_tk;
    logic [15:0] cnt_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic pv, input logic [31:0] pc, input logic h,
                        input logic [31:0] ppc, input logic pt,
                        input logic ev, input logic et, input logic [31:0] tgt);
        @(negedge clk);
        push_valid = pv; push_pc = pc; push_hit = h; push_pred_pc = ppc;
        push_pred_taken = pt; ex_valid = ev; ex_taken = et; ex_target = tgt;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic push(input logic [31:0] pc, input logic h, input logic [31:0] ppc, input logic pt);
        step(1'b1, pc, h, ppc, pt, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic resolve(input logic et, input logic [31:0] tgt);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, et, tgt);
    endtask

    // Expected response for the next resolve; fields hold when no command issues
    task automatic expect_cmd(input logic [2:0] we, input logic [31:0] pc, input logic [31:0] ppc,
                              input logic tk, input logic fl, input logic [31:0] rpc);
        exp_t e;
        if (we != 3'b000) begin
            last_pc = pc; last_ppc = ppc; last_tk = tk;
        end
        if (fl && (cnt_m != 16'hFFFF)) cnt_m = cnt_m + 16'd1;
        e = '{we, last_pc, last_ppc, last_tk, fl, rpc, cnt_m};
        sb.push_back(e);
    endtask

    // Monitor: a resolve sampled at an edge is answered right after that edge
    initial begin : monitor
        logic ev;
        exp_t e;
        forever begin
            @(posedge clk);
            ev = ex_valid && !rst;
            #1;
            if (ev) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_resolve", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("write_entry", 32'(write_entry), 32'(e.we));
                    chk("pc_ip", pc_ip, e.pc);
                    chk("pc_predicted_ip", pc_predicted_ip, e.ppc);
                    chk("taken_ip", 32'(taken_ip), 32'(e.tk));
                    chk("flush", 32'(flush), 32'(e.fl));
                    if (e.fl) chk("redirect_pc", redirect_pc, e.rpc);
                    chk("mispredict_count", 32'(mispredict_count), 32'(e.cnt));
                end
            end else begin
                chk("idle_write_entry", 32'(write_entry), 32'd0);
                chk("idle_flush", 32'(flush), 32'd0);
            end
        end
    end

    initial begin : driver
        rst = 1'b1;
        push_valid = 1'b0; push_pc = '0; push_hit = 1'b0; push_pred_pc = '0;
        push_pred_taken = 1'b0; ex_valid = 1'b0; ex_taken = 1'b0; ex_target = '0;
        last_pc = '0; last_ppc = '0; last_tk = 1'b0; cnt_m = '0;
        repeat (2) @(negedge clk);
        chk("rst_write_entry", 32'(write_entry), 32'd0);
        chk("rst_pc_ip", pc_ip, 32'd0);
        chk("rst_pc_predicted_ip", pc_predicted_ip, 32'd0);
        chk("rst_taken_ip", 32'(taken_ip), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_count", 32'(mispredict_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        rst = 1'b0;

        // Miss, taken: allocate and flush to target
        push(32'h40, 1'b0, 32'h0, 1'b0);
        expect_cmd(3'b010, 32'h40, 32'h80, 1'b1, 1'b1, 32'h80);
        resolve(1'b1, 32'h80);
        idle();
        chk("t1_empty", 32'(empty), 32'd1);

        // Hit, correctly predicted taken: no command
        push(32'h100, 1'b1, 32'h200, 1'b1);
        expect_cmd(3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        resolve(1'b1, 32'h200);
        idle();
        chk("t2_empty", 32'(empty), 32'd1);

        // Hit predicted taken, actually not taken, with two younger records
        push(32'h100, 1'b1, 32'h200, 1'b1);
        push(32'h104, 1'b0, 32'h0, 1'b0);
        push(32'h108, 1'b0, 32'h0, 1'b0);
        expect_cmd(3'b001, 32'h100, 32'h200, 1'b0, 1'b1, 32'h104);
        resolve(1'b0, 32'h0);
        idle();
        chk("t3_empty_after_flush", 32'(empty), 32'd1);

        // Fill, overflow, simultaneous push+correct resolve, then FIFO drain
        push(32'h10, 1'b1, 32'h1000, 1'b1);
        push(32'h14, 1'b1, 32'h1010, 1'b1);
        push(32'h18, 1'b1, 32'h1020, 1'b1);
        push(32'h1C, 1'b1, 32'h1030, 1'b1);
        push(32'h20, 1'b1, 32'h9999, 1'b1);
        chk("t4_full", 32'(full), 32'd1);
        chk("t4_not_overflow_yet", 32'(overflow), 32'd0);
        expect_cmd(3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h24, 1'b1, 32'h1040, 1'b1, 1'b1, 1'b1, 32'h1000);
        chk("t4_overflow", 32'(overflow), 32'd1);
        chk("t4_full_before_swap", 32'(full), 32'd1);
        expect_cmd(3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        resolve(1'b1, 32'h1010);
        chk("t4_full_after_swap", 32'(full), 32'd1);
        expect_cmd(3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        resolve(1'b1, 32'h1020);
        expect_cmd(3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        resolve(1'b1, 32'h1030);
        expect_cmd(3'b001, 32'h24, 32'h1040, 1'b0, 1'b1, 32'h28);
        resolve(1'b0, 32'h0);
        idle();
        chk("t4_empty", 32'(empty), 32'd1);
        chk("t4_full_clear", 32'(full), 32'd0);

        // Resolve while empty
        chk("t5_no_underflow_yet", 32'(underflow), 32'd0);
        expect_cmd(3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        resolve(1'b1, 32'h999);
        idle();
        chk("t5_underflow", 32'(underflow), 32'd1);
        chk("t5_empty", 32'(empty), 32'd1);

        // Asynchronous reset with three records queued
        push(32'h300, 1'b1, 32'h400, 1'b1);
        push(32'h304, 1'b1, 32'h404, 1'b1);
        push(32'h308, 1'b1, 32'h408, 1'b1);
        idle();
        chk("t6_not_empty", 32'(empty), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_full", 32'(full), 32'd0);
        chk("t6_pc_ip", pc_ip, 32'd0);
        chk("t6_pc_predicted_ip", pc_predicted_ip, 32'd0);
        chk("t6_count", 32'(mispredict_count), 32'd0);
        chk("t6_overflow", 32'(overflow), 32'd0);
        chk("t6_underflow", 32'(underflow), 32'd0);
        last_pc = '0; last_ppc = '0; last_tk = 1'b0; cnt_m = '0;
        @(negedge clk);
        rst = 1'b0;

        // Counter saturation, pc+4 wrap, push discarded by a mispredicting resolve
        @(negedge clk);
        force dut.mispredict_count = 16'hFFFE;
        #1 release dut.mispredict_count;
        cnt_m = 16'hFFFE;
        push(32'h50, 1'b0, 32'h0, 1'b0);
        expect_cmd(3'b010, 32'h50, 32'h60, 1'b1, 1'b1, 32'h60);
        resolve(1'b1, 32'h60);
        push(32'hFFFF_FFFC, 1'b1, 32'h8, 1'b1);
        expect_cmd(3'b001, 32'hFFFF_FFFC, 32'h8, 1'b0, 1'b1, 32'h0);
        step(1'b1, 32'h77, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        idle();
        chk("t7_count_sat", 32'(mispredict_count), 32'hFFFF);
        chk("t7_empty_push_discarded", 32'(empty), 32'd1);
        chk("t7_no_overflow", 32'(overflow), 32'd0);

        repeat (3) idle();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolution_unit.md
# branch_resolution_unit

Closes the prediction loop for the fetch-stage branch target buffer. Holds each in-flight branch's fetch-time prediction in an ordered queue, compares it with the actual outcome from EX, and drives the buffer's update port (`WriteEntry`, `PC_ip`, `PC_predicted_ip`, `taken_ip`). On a misprediction it issues a one-cycle pipeline flush with the corrected fetch PC. Sits between ID (push) and EX (resolve), alongside the fetch PC mux.

## Interface
- `DEPTH`, 4: prediction queue entries; power of two, 2..16.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `push_valid` input 1: ID has decoded a branch; record its prediction.
- `push_pc` input 32: branch instruction PC.
- `push_hit` input 1: buffer lookup hit (`FindinBTB`) at fetch.
- `push_pred_pc` input 32: predicted target from the buffer.
- `push_pred_taken` input 1: predicted direction from the buffer.
- `ex_valid` input 1: EX resolves the oldest outstanding branch this cycle.
- `ex_taken` input 1: actual direction.
- `ex_target` input 32: actual taken target.
- `full` output 1: queue holds `DEPTH` records.
- `empty` output 1: queue holds no records.
- `write_entry` output 3: buffer command {UsePCstage2, Noentry, Decision}; bit 2 is always 0.
- `pc_ip` output 32: update PC.
- `pc_predicted_ip` output 32: update target.
- `taken_ip` output 1: update direction.
- `flush` output 1: one-cycle squash of IF/ID and the queue.
- `redirect_pc` output 32: corrected fetch PC, valid while `flush`=1.
- `mispredict_count` output 16: saturating misprediction count.
- `overflow` output 1: sticky; push arrived while full.
- `underflow` output 1: sticky; resolve arrived while empty.

## Operation
- Queue: circular buffer of {pc, hit, pred_pc, pred_taken}; read/write pointers carry one extra wrap bit; `full`/`empty` derive from the pointers.
- Push: records the entry when `push_valid`=1 and the queue is not full. A push while full is dropped and sets `overflow`.
- Resolve: `ex_valid` pops the head. A resolve while empty does nothing else and sets `underflow`.
- Effective prediction: `eff_taken = hit & pred_taken`.
- Mispredict when `eff_taken != ex_taken`, or when `ex_taken` = 1 and `pred_pc != ex_target`.
- Buffer command, registered:
  - Hit and mispredict: 3'b001 (overwrite) with {pc, ex_target, ex_taken}. On not-taken, `pc_predicted_ip` carries the head's `pred_pc`.
  - No hit and `ex_taken`=1: 3'b010 (allocate) with {pc, ex_target, 1}.
  - Otherwise 3'b000. A no-hit, not-taken branch is never allocated.
- `write_entry` is high for exactly one cycle, then 3'b000. `pc_ip`, `pc_predicted_ip` and `taken_ip` hold their last value until the next command, because the buffer's update path is level-sensitive.
- Flush on mispredict:
  - `flush`=1 for one cycle.
  - `redirect_pc` = `ex_target` if taken, else `pc + 32'd4` (mod 2^32).
  - The queue is emptied: all younger records are wrong-path.
  - `mispredict_count` increments and saturates at 16'hFFFF.
- Same cycle as a mispredicting resolve: a push is discarded, not counted as overflow, and the queue is empty afterwards.
- Push with a correct resolve in the same cycle: both take effect and the occupancy is unchanged. This is legal even when full, because the pop frees the slot first.
- Reset mid-operation clears the queue immediately. Any pending command or flush is lost.

## Timing
- Reset values:
  - `write_entry` = 0, `pc_ip` = 0, `pc_predicted_ip` = 0, `taken_ip` = 0.
  - `flush` = 0, `redirect_pc` = 0, `mispredict_count` = 0.
  - `overflow` = 0, `underflow` = 0.
  - `full` = 0, `empty` = 1.
- Push at edge N: the record is visible and `empty`/`full` update after edge N.
- Resolve sampled at edge N: `write_entry`, the update fields, `flush` and `redirect_pc` are valid in cycle N+1 (one-cycle latency, all registered).
- Back-to-back resolves produce back-to-back one-cycle commands with no bubble.
- The cycle after `flush`, the queue is empty and accepts pushes normally.

## Test plan
- Reset, then push {0x40, hit=0, 0, 0}, resolve taken to 0x80 -> next cycle `write_entry`=010, `pc_ip`=0x40, `pc_predicted_ip`=0x80, `taken_ip`=1, `flush`=1, `redirect_pc`=0x80, count=1.
- Push {0x100, hit=1, 0x200, 1}, resolve taken to 0x200 -> `write_entry`=000, `flush`=0, count unchanged.
- Push {0x100, hit=1, 0x200, 1}, then pushes 0x104 and 0x108, then resolve not-taken -> `write_entry`=001, `taken_ip`=0, `redirect_pc`=0x104, `empty`=1 next cycle.
- Fill 4 entries and push a 5th -> `full`=1 and `overflow`=1. Then a simultaneous push and correct resolve -> occupancy stays 4 with no new overflow. Then drain all 4 in FIFO order -> PCs match the push order.
- Resolve while empty -> `underflow`=1, `write_entry`=000, `flush`=0. Assert `rst` mid-stream with 3 queued -> `empty`=1 and all outputs 0 immediately.
- Force `mispredict_count` to 16'hFFFE via 2 mispredicts after preload, or by running 65535 mispredicts -> it saturates at 16'hFFFF.
